// File: rtl/demux_clk_edge_in_if.sv
// Pin-side bundle for the clock-phase demux: enable, shared data wire,
// and the valid/ready drain port with drop status.
interface demux_clk_edge_in_if #(
  parameter int WIDTH     = 7,
  parameter int CNT_WIDTH = 8
) ();
  logic                 en;
  logic [WIDTH-1:0]     din;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_pos;
  logic [WIDTH-1:0]     out_neg;
  logic [CNT_WIDTH-1:0] drop_cnt;
  logic                 overflow;

  modport master (
    output en, din, out_ready,
    input  out_valid, out_pos, out_neg, drop_cnt, overflow
  );

  modport slave (
    input  en, din, out_ready,
    output out_valid, out_pos, out_neg, drop_cnt, overflow
  );
endinterface

// File: rtl/demux_clk_edge_in.sv
// Recovers (pos, neg) pairs from a clock-phase multiplexed wire and queues
// them in a 2-entry posedge FIFO; pairs arriving while full are dropped.
module demux_clk_edge_in #(
  parameter int WIDTH     = 7,
  parameter int CNT_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  demux_clk_edge_in_if.slave  bus
);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [WIDTH-1:0]     cap_pos_d, cap_pos_q;
  logic                 en_reg_d, en_reg_q;
  logic [1:0]           count_d, count_q;
  logic                 head_d, head_q;
  logic [WIDTH-1:0]     pos_mem_d [2];
  logic [WIDTH-1:0]     pos_mem_q [2];
  logic [WIDTH-1:0]     neg_mem_d [2];
  logic [WIDTH-1:0]     neg_mem_q [2];
  logic [CNT_WIDTH-1:0] drop_cnt_d, drop_cnt_q;
  logic                 overflow_d, overflow_q;
  logic                 pop, push, drop, tail;

  // Stage 0: falling edge grabs the high-phase value before the wire flips
  always_comb begin
    cap_pos_d = bus.din;
  end

  always_ff @(negedge clk) begin
    if (!rst_n) cap_pos_q <= '0;
    else        cap_pos_q <= cap_pos_d;
  end

  // Stage 1: rising edge pairs cap_pos with the low-phase value and queues it
  always_comb begin
    pop      = (count_q != 2'd0) && bus.out_ready;
    push     = en_reg_q && ((count_q != 2'd2) || pop);
    drop     = en_reg_q && (count_q == 2'd2) && !pop;
    // slot after the last valid entry; wraps onto head when full
    tail     = head_q ^ count_q[0];

    en_reg_d = bus.en;
    head_d   = pop ? ~head_q : head_q;

    count_d  = count_q;
    if (push && !pop)      count_d = count_q + 2'd1;
    else if (pop && !push) count_d = count_q - 2'd1;

    pos_mem_d = pos_mem_q;
    neg_mem_d = neg_mem_q;
    if (push) begin
      pos_mem_d[tail] = cap_pos_q;
      neg_mem_d[tail] = bus.din;
    end

    drop_cnt_d = drop ? sat_inc(drop_cnt_q) : drop_cnt_q;
    overflow_d = overflow_q | drop;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_reg_q   <= 1'b0;
      count_q    <= 2'd0;
      head_q     <= 1'b0;
      pos_mem_q  <= '{default: '0};
      neg_mem_q  <= '{default: '0};
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      en_reg_q   <= en_reg_d;
      count_q    <= count_d;
      head_q     <= head_d;
      pos_mem_q  <= pos_mem_d;
      neg_mem_q  <= neg_mem_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.out_valid = (count_q != 2'd0);
  assign bus.out_pos   = (count_q != 2'd0) ? pos_mem_q[head_q] : '0;
  assign bus.out_neg   = (count_q != 2'd0) ? neg_mem_q[head_q] : '0;
  assign bus.drop_cnt  = drop_cnt_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: doc/demux_clk_edge_in.md
Name: demux_clk_edge_in

Overview:
- Receive-side counterpart of the clock-phase output mux. The transmitter drives its "pos" value while clk is high and its "neg" value while clk is low.
- This block recovers both halves from the shared wire, reassembles each (pos, neg) pair into the posedge domain, and queues it in a 2-entry buffer.
- Consumers drain the buffer through a valid/ready handshake. Pairs that arrive while the buffer is full are dropped and counted.
- Sits at the input boundary of the multiplier datapath, facing the same chip-level pins.

Parameters:
- WIDTH, 7, width of each half-cycle data value
- CNT_WIDTH, 8, width of the saturating drop counter

Ports:
- clk  input  1  single clock; both edges used for capture
- rst_n  input  1  synchronous active-low reset, sampled on clk rising edge (and at the falling edge by the negedge capture register, see Behaviour)
- en  input  1  capture enable, qualifies the pair transmitted in the current cycle
- din  input  WIDTH  clock-phase multiplexed data wire
- out_valid  output  1  buffer non-empty
- out_ready  input  1  consumer accepts head entry
- out_pos  output  WIDTH  head entry, value carried during clk-high phase
- out_neg  output  WIDTH  head entry, value carried during clk-low phase
- drop_cnt  output  CNT_WIDTH  saturating count of dropped pairs
- overflow  output  1  sticky, set on first drop

Behaviour:
- Transmit cycle N: runs from rising edge R(N) to rising edge R(N+1). The high phase carries pos, then the low phase carries neg.
- Falling-edge capture: cap_pos <= din at the falling edge inside cycle N. This is the only negedge register. When rst_n is low at that falling edge, cap_pos <= 0.
- Rising-edge pairing: at R(N+1), pair = {cap_pos, din}. din is sampled directly, end of the low phase.
- en qualification: en is registered at R(N) into en_d. The pair is pushed at R(N+1) only if en_d = 1.
- Latency: a pair transmitted in cycle N shows out_valid = 1 during cycle N+1 if the buffer was empty. That is one rising edge after transmission ends.
- Buffer: 2-entry FIFO, in-order. Posedge only.
  - Pop when out_valid && out_ready at a rising edge.
  - Push when the pair is qualified and (count < 2 or pop in the same edge).
- Simultaneous push and pop:
  - With 1 entry: count stays 1, and the head becomes the new pair.
  - With 2 entries: accepted, no drop.
- Drop: the pair is qualified, count = 2 and no pop.
  - The pair is discarded and FIFO contents are unchanged.
  - drop_cnt increments and saturates at 2^CNT_WIDTH-1.
  - overflow is set to 1 and is cleared only by reset.
- Outputs: out_valid = (count != 0). When empty, out_pos = out_neg = 0. When valid, they hold the head until popped.
- Reset (rst_n low at a rising edge):
  - count = 0, out_valid = 0, out_pos = out_neg = 0.
  - en_d = 0, drop_cnt = 0, overflow = 0.
  - FIFO storage cleared; any pair in flight is discarded.
  - Reset mid-stream loses all queued data with no drop counted.
  - After release, the earliest push is at the second rising edge with en = 1 held: en_d is loaded at the first edge, the push happens at the next.
- No combinational path from din or en to any output. out_valid, out_pos and out_neg depend only on registers.

Test Plan:
1. After reset, en=1, out_ready=1; transmitter drives pos=7'h55 (high phase) and neg=7'h2A (low phase) in cycle 1 -> out_valid=1 for exactly cycle 2 with out_pos=7'h55 and out_neg=7'h2A, then 0.
2. Four back-to-back pairs (11,22), (33,44), (55,66), (77,00) with out_ready=1 -> four consecutive valid cycles, in order, each one cycle after transmission, drop_cnt=0.
3. out_ready=0 while pushing pairs A, B, C -> A and B retained, C dropped, drop_cnt=1, overflow=1. Then raise out_ready -> A then B emerge, then out_valid=0, and overflow stays 1.
4. Buffer full with out_ready=1 at the same edge as a qualified push -> no drop, count stays 2, head advances to the second entry, new pair queued behind it.
5. CNT_WIDTH=2, out_ready=0, five drops -> drop_cnt reads 1, 2, 3, 3, 3.
6. Buffer holding 2 entries with drop_cnt=3, pull rst_n low for one edge -> next cycle out_valid=0, drop_cnt=0, overflow=0. With en=1 after release, the first valid output appears only for a pair whose cycle began after en_d was loaded. en=0 throughout -> never valid.
